conv_sched: RTL and testbench
=============================

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter RST_CYC, default 2: number of cycles the converter restart (cv_rst_n low) is held per transaction, legal 1..15.
REQ-002 Parameter TIMEOUT, default 255: maximum WAIT cycles before a transaction is aborted, legal 1..255.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 req_a, req_b  input  1 each  level request from requester A or B; held until the matching done pulse.
REQ-006 a_data, b_data  input  40 each  operand bundle {int1[9:0], int2[9:0], frac1[9:0], frac2[9:0]}.
REQ-007 gnt_a, gnt_b  output  1 each  grant; high for the whole transaction of the winner.
REQ-008 done_a, done_b  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 err  output  1  high with done when the transaction timed out.
REQ-010 res_digit  output  12  captured converter digit result.
REQ-011 res_dp  output  9  captured converter decimal-point result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 cv_deci1, cv_deci2, cv_decp1, cv_decp2  output  10 each  registered operands to the shared converter.
REQ-014 cv_rst_n  output  1  active-low converter restart.
REQ-015 cv_complete  input  1  converter done flag; cv_digit (12) and cv_dp (9) inputs carry its result.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, WAIT, DONE; exactly one grant is high in LOAD/WAIT/DONE, none in IDLE.
REQ-017 In IDLE, if either req is sampled high at an edge, the next state SHALL be LOAD, the winner's gnt SHALL rise and the winner's data SHALL be registered onto cv_* at that same edge.
REQ-018 Arbitration SHALL be round-robin: with one request, that requester wins; with both, the requester not granted last wins; after reset A has priority.
REQ-019 In LOAD, cv_rst_n SHALL be 0 for exactly RST_CYC cycles, then the FSM SHALL enter WAIT with cv_rst_n = 1.
REQ-020 cv_complete SHALL be ignored in LOAD; in WAIT, cv_complete = 1 at an edge SHALL capture cv_digit/cv_dp into res_digit/res_dp and enter DONE.
REQ-021 An 8-bit counter SHALL count WAIT cycles; if it reaches TIMEOUT without cv_complete, the FSM SHALL enter DONE with err = 1 and res_* unchanged.
REQ-022 cv_complete and timeout in the same cycle: completion wins, err = 0.
REQ-023 DONE lasts one cycle: winner's done = 1, err valid; next state IDLE, gnt falls on that edge.
REQ-024 Requester dropping req mid-transaction SHALL NOT abort it; done is still pulsed.
REQ-025 Changes on a_data/b_data after the grant edge SHALL NOT affect cv_* for the current transaction.
REQ-026 res_digit/res_dp SHALL hold their value until the next successful capture.
REQ-027 Minimum transaction latency: grant edge to done = RST_CYC + 1 cycles (complete high on first WAIT cycle) then done for one cycle.

Reset
REQ-028 RST low SHALL asynchronously force IDLE, gnt/done/err/busy = 0, res_* = 0, cv_* operands = 0, cv_rst_n = 0, counters = 0, last-grant = B (so A wins first tie).
REQ-029 cv_rst_n SHALL be 1 in IDLE after reset release; RST asserted mid-transaction aborts it with no done pulse.

Verification
REQ-030 Single A: req_a=1, a_data={10'd2,10'd2,10'h080,10'h004}, complete 3 cycles into WAIT with cv_digit=12'h123, cv_dp=9'h004 -> cv_rst_n low 2 cycles, done_a one cycle, res_digit=12'h123, res_dp=9'h004, err=0.
REQ-031 Tie: req_a=req_b=1 from reset -> A served first, then B, then A again on repeated tie; never two grants high.
REQ-032 Timeout: TIMEOUT=8, cv_complete held 0 -> done pulse after 8 WAIT cycles with err=1, res_* keep previous value.
REQ-033 Stale complete: cv_complete held 1 through LOAD -> no capture before WAIT; capture on first WAIT cycle.
REQ-034 Reset mid-WAIT: RST low -> outputs at REQ-028 values immediately, no done; after release req_a still high -> new transaction starts.
REQ-035 Data change: a_data altered one cycle after grant -> cv_* unchanged until next transaction.

Source files
------------

// File: rtl/conv_sched.sv
// Round-robin scheduler sharing one converter between requesters A and B.
// It restarts the converter for RST_CYC cycles, waits for completion or a timeout, then pulses done.
module conv_sched #(
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_a_i,
  input  logic        req_b_i,
  input  logic [39:0] a_data_i,
  input  logic [39:0] b_data_i,
  output logic        gnt_a_o,
  output logic        gnt_b_o,
  output logic        done_a_o,
  output logic        done_b_o,
  output logic        err_o,
  output logic [11:0] res_digit_o,
  output logic [8:0]  res_dp_o,
  output logic        busy_o,
  output logic [9:0]  cv_deci1_o,
  output logic [9:0]  cv_deci2_o,
  output logic [9:0]  cv_decp1_o,
  output logic [9:0]  cv_decp2_o,
  output logic        cv_rst_no,
  input  logic        cv_complete_i,
  input  logic [11:0] cv_digit_i,
  input  logic [8:0]  cv_dp_i
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [3:0] LoadLast = 4'(RST_CYC - 1);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        gnt_a_q, gnt_a_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic        err_q, err_d;
  logic [3:0]  ld_cnt_q, ld_cnt_d;
  logic [7:0]  wt_cnt_q, wt_cnt_d;
  logic [11:0] res_digit_q, res_digit_d;
  logic [8:0]  res_dp_q, res_dp_d;
  logic [39:0] opnd_q, opnd_d;
  logic        cv_rst_n_q, cv_rst_n_d;
  logic        pick_a;

  // A wins alone, or on a tie when B was served last.
  assign pick_a = req_a_i & (~req_b_i | last_b_q);

  always_comb begin
    state_d     = state_q;
    gnt_a_d     = gnt_a_q;
    gnt_b_d     = gnt_b_q;
    last_b_d    = last_b_q;
    err_d       = err_q;
    ld_cnt_d    = ld_cnt_q;
    wt_cnt_d    = wt_cnt_q;
    res_digit_d = res_digit_q;
    res_dp_d    = res_dp_q;
    opnd_d      = opnd_q;
    case (state_q)
      StIdle: begin
        err_d = 1'b0;
        if (req_a_i || req_b_i) begin
          state_d  = StLoad;
          gnt_a_d  = pick_a;
          gnt_b_d  = ~pick_a;
          last_b_d = ~pick_a;
          opnd_d   = pick_a ? a_data_i : b_data_i;
          ld_cnt_d = 4'd0;
        end
      end
      StLoad: begin
        if (ld_cnt_q == LoadLast) begin
          state_d  = StWait;
          wt_cnt_d = 8'd0;
        end else begin
          ld_cnt_d = ld_cnt_q + 4'd1;
        end
      end
      StWait: begin
        // Completion takes precedence over a timeout in the same cycle.
        if (cv_complete_i) begin
          state_d     = StDone;
          res_digit_d = cv_digit_i;
          res_dp_d    = cv_dp_i;
          err_d       = 1'b0;
        end else if (wt_cnt_q == WaitLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          wt_cnt_d = wt_cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_a_d = 1'b0;
        gnt_b_d = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    cv_rst_n_d = (state_d != StLoad);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      gnt_a_q     <= 1'b0;
      gnt_b_q     <= 1'b0;
      last_b_q    <= 1'b1;
      err_q       <= 1'b0;
      ld_cnt_q    <= 4'd0;
      wt_cnt_q    <= 8'd0;
      res_digit_q <= 12'd0;
      res_dp_q    <= 9'd0;
      opnd_q      <= 40'd0;
      cv_rst_n_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_a_q     <= gnt_a_d;
      gnt_b_q     <= gnt_b_d;
      last_b_q    <= last_b_d;
      err_q       <= err_d;
      ld_cnt_q    <= ld_cnt_d;
      wt_cnt_q    <= wt_cnt_d;
      res_digit_q <= res_digit_d;
      res_dp_q    <= res_dp_d;
      opnd_q      <= opnd_d;
      cv_rst_n_q  <= cv_rst_n_d;
    end
  end

  assign gnt_a_o     = gnt_a_q;
  assign gnt_b_o     = gnt_b_q;
  assign done_a_o    = (state_q == StDone) & gnt_a_q;
  assign done_b_o    = (state_q == StDone) & gnt_b_q;
  assign err_o       = err_q;
  assign res_digit_o = res_digit_q;
  assign res_dp_o    = res_dp_q;
  assign busy_o      = (state_q != StIdle);
  assign cv_deci1_o  = opnd_q[39:30];
  assign cv_deci2_o  = opnd_q[29:20];
  assign cv_decp1_o  = opnd_q[19:10];
  assign cv_decp2_o  = opnd_q[9:0];
  assign cv_rst_no   = cv_rst_n_q;

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: a table of transactions plus a mid-transaction reset sequence.
module tb_conv_sched;

  localparam int RstCyc  = 2;
  localparam int Timeout = 8;

  logic        clk, rst_n;
  logic        req_a, req_b;
  logic [39:0] a_data, b_data;
  logic        gnt_a, gnt_b, done_a, done_b, err;
  logic [11:0] res_digit;
  logic [8:0]  res_dp;
  logic        busy;
  logic [9:0]  cv_deci1, cv_deci2, cv_decp1, cv_decp2;
  logic        cv_rst_n, cv_complete;
  logic [11:0] cv_digit;
  logic [8:0]  cv_dp;

  int n_cmp = 0;
  int n_bad = 0;

  conv_sched #(.RST_CYC(RstCyc), .TIMEOUT(Timeout)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_a_i(req_a), .req_b_i(req_b),
    .a_data_i(a_data), .b_data_i(b_data), .gnt_a_o(gnt_a), .gnt_b_o(gnt_b),
    .done_a_o(done_a), .done_b_o(done_b), .err_o(err), .res_digit_o(res_digit),
    .res_dp_o(res_dp), .busy_o(busy), .cv_deci1_o(cv_deci1), .cv_deci2_o(cv_deci2),
    .cv_decp1_o(cv_decp1), .cv_decp2_o(cv_decp2), .cv_rst_no(cv_rst_n),
    .cv_complete_i(cv_complete), .cv_digit_i(cv_digit), .cv_dp_i(cv_dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k: WAIT cycle (1-based) in which complete is driven; 0 means never (timeout).
  typedef struct {
    logic        ra, rb;
    logic [39:0] da, db;
    int          k;
    logic        stale, drop;
    logic [11:0] dig;
    logic [8:0]  dp;
    logic        exp_a, exp_err;
    logic [11:0] exp_dig;
    logic [8:0]  exp_dp;
  } vec_t;

  vec_t vecs[6];
  vec_t vtie;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    logic [39:0] op;
    int          w, lo, done_n, exp_n;
    req_a = v.ra; req_b = v.rb; a_data = v.da; b_data = v.db;
    cv_complete = v.stale; cv_digit = v.dig; cv_dp = v.dp;
    w = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (gnt_a || gnt_b) begin
        w = i;
        break;
      end
    end
    check("grant_latency", w, 1);
    if (w == 0) return;
    op = v.exp_a ? v.da : v.db;
    check("gnt_a", gnt_a, v.exp_a);
    check("gnt_b", gnt_b, !v.exp_a);
    check("cv_deci1", cv_deci1, op[39:30]);
    check("cv_deci2", cv_deci2, op[29:20]);
    check("cv_decp1", cv_decp1, op[19:10]);
    check("cv_decp2", cv_decp2, op[9:0]);
    a_data = ~v.da;
    b_data = ~v.db;
    if (v.drop) begin
      if (v.exp_a) req_a = 1'b0;
      else req_b = 1'b0;
    end
    lo = 0;
    done_n = -1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) @(negedge clk);
      if (done_a || done_b) begin
        done_n = n;
        break;
      end
      if (!cv_rst_n) lo++;
      cv_complete = (n < RstCyc) ? v.stale : (v.k != 0 && n == RstCyc + v.k - 1);
    end
    exp_n = RstCyc + ((v.k == 0) ? Timeout : v.k);
    check("done_latency", done_n, exp_n);
    check("cv_rst_low_cycles", lo, RstCyc);
    check("done_a", done_a, v.exp_a);
    check("done_b", done_b, !v.exp_a);
    check("err", err, v.exp_err);
    check("res_digit", res_digit, v.exp_dig);
    check("res_dp", res_dp, v.exp_dp);
    check("cv_deci1_held", cv_deci1, op[39:30]);
    check("cv_decp2_held", cv_decp2, op[9:0]);
    check("gnt_in_done", {gnt_a, gnt_b}, {v.exp_a, !v.exp_a});
    cv_complete = 1'b0;
    if (v.exp_a) req_a = 1'b0;
    else req_b = 1'b0;
    @(negedge clk);
    check("idle_gnt", {gnt_a, gnt_b}, 2'b00);
    check("idle_done", {done_a, done_b}, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("idle_err", err, 1'b0);
    check("idle_cv_rst_n", cv_rst_n, 1'b1);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, {10'd2, 10'd2, 10'h080, 10'h004}, 40'h0, 3, 1'b0, 1'b0,
                12'h123, 9'h004, 1'b1, 1'b0, 12'h123, 9'h004};
    vecs[1] = '{1'b0, 1'b1, 40'h0, {10'd5, 10'd6, 10'h1ff, 10'h3ff}, 1, 1'b0, 1'b0,
                12'hABC, 9'h1F0, 1'b0, 1'b0, 12'hABC, 9'h1F0};
    vecs[2] = '{1'b1, 1'b1, {10'd7, 10'd1, 10'h2AA, 10'h155}, {10'd4, 10'd4, 10'h011, 10'h022},
                2, 1'b0, 1'b1, 12'h456, 9'h0AA, 1'b1, 1'b0, 12'h456, 9'h0AA};
    vecs[3] = '{1'b1, 1'b1, {10'd8, 10'd8, 10'h001, 10'h002}, {10'd3, 10'd9, 10'h0F0, 10'h00F},
                0, 1'b0, 1'b0, 12'h777, 9'h155, 1'b0, 1'b1, 12'h456, 9'h0AA};
    vecs[4] = '{1'b1, 1'b1, {10'd1, 10'd0, 10'h3FF, 10'h001}, {10'd2, 10'd2, 10'h000, 10'h000},
                1, 1'b1, 1'b0, 12'h321, 9'h00F, 1'b1, 1'b0, 12'h321, 9'h00F};
    vecs[5] = '{1'b1, 1'b0, {10'd9, 10'd9, 10'h100, 10'h200}, 40'h0, 8, 1'b0, 1'b0,
                12'h9E5, 9'h1A3, 1'b1, 1'b0, 12'h9E5, 9'h1A3};
    vtie    = '{1'b1, 1'b1, {10'd6, 10'd6, 10'h006, 10'h006}, {10'd8, 10'd8, 10'h008, 10'h008},
                1, 1'b0, 1'b0, 12'h5A5, 9'h0C3, 1'b1, 1'b0, 12'h5A5, 9'h0C3};

    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; a_data = '0; b_data = '0;
    cv_complete = 1'b0; cv_digit = '0; cv_dp = '0;
    #12;
    check("rst_gnt", {gnt_a, gnt_b}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_cv_rst_n", cv_rst_n, 1'b0);
    check("rst_res_digit", res_digit, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_rst_cv_rst_n", cv_rst_n, 1'b1);
    check("idle_after_rst_busy", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Reset in the middle of WAIT on an A grant; the following tie must still go to A.
    req_a = 1'b1; req_b = 1'b0; a_data = 40'h12345_6789A; cv_complete = 1'b0;
    repeat (RstCyc + 3) @(negedge clk);
    check("mid_busy_before_rst", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", {gnt_a, gnt_b}, 2'b00);
    check("mid_rst_done", {done_a, done_b}, 2'b00);
    check("mid_rst_busy_err", {busy, err}, 2'b00);
    check("mid_rst_res", {res_digit, res_dp}, 21'h0);
    check("mid_rst_cv_opnd", {cv_deci1, cv_decp2}, 20'h0);
    check("mid_rst_cv_rst_n", cv_rst_n, 1'b0);
    req_b = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(vtie);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
